// File: rtl/spi_command_framer.sv
// SPI byte-stream command framer: resynchronises the shifter strobe and
// assembles 6-byte SD-style command frames with a CRC7 verdict.
module spi_command_framer #(
  parameter int SYNC_STAGES = 2,
  parameter bit CHECK_CRC   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_InputBuffer,
  input  logic        io_BufferChanged,
  input  logic        io_ChipSelect,
  input  logic        io_Cmd_ready,
  output logic        io_Cmd_valid,
  output logic [5:0]  io_Cmd_index,
  output logic [31:0] io_Cmd_arg,
  output logic        io_Cmd_crcOk,
  output logic        io_Overrun,
  output logic [7:0]  io_FrameCount
);

  typedef enum logic [1:0] {
    IDLE,
    ARG,
    CRC,
    HOLD
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] chg_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   chg_prev;
  logic                   byte_evt;
  logic                   evt_q;
  logic [7:0]             byte_q;
  logic                   cs;
  logic [1:0]             cnt;
  logic [6:0]             crc;
  logic [5:0]             idx;
  logic [31:0]            arg;
  logic [6:0]             crc_start;
  logic [6:0]             crc_next;
  logic                   crc_good;

  // x^7 + x^3 + 1, MSB first, eight bit steps unrolled per byte
  function automatic logic [6:0] crc7_step(
    input logic [6:0] c,
    input logic [7:0] d
  );
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ d[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction

  assign byte_evt  = chg_sync[SYNC_STAGES-1] & ~chg_prev;
  assign cs        = cs_sync[SYNC_STAGES-1];
  assign crc_start = crc7_step(7'd0, byte_q);
  assign crc_next  = crc7_step(crc, byte_q);
  assign crc_good  = CHECK_CRC ? ((byte_q[7:1] == crc) & byte_q[0])
                               : byte_q[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chg_sync <= '0;
      cs_sync  <= '0;
      chg_prev <= 1'b0;
      evt_q    <= 1'b0;
      byte_q   <= 8'd0;
    end else begin
      chg_sync <= {chg_sync[SYNC_STAGES-2:0], io_BufferChanged};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], io_ChipSelect};
      chg_prev <= chg_sync[SYNC_STAGES-1];
      evt_q    <= byte_evt;
      if (byte_evt) byte_q <= io_InputBuffer;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= 2'd0;
      crc           <= 7'd0;
      idx           <= 6'd0;
      arg           <= 32'd0;
      io_Cmd_valid  <= 1'b0;
      io_Cmd_index  <= 6'd0;
      io_Cmd_arg    <= 32'd0;
      io_Cmd_crcOk  <= 1'b0;
      io_Overrun    <= 1'b0;
      io_FrameCount <= 8'd0;
    end else begin
      io_Overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (evt_q && byte_q[7:6] == 2'b01) begin
            idx   <= byte_q[5:0];
            crc   <= crc_start;
            cnt   <= 2'd0;
            state <= ARG;
          end
        end
        ARG: begin
          if (cs) begin
            state <= IDLE;
          end else if (evt_q) begin
            arg <= {arg[23:0], byte_q};
            crc <= crc_next;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= CRC;
          end
        end
        CRC: begin
          if (cs) begin
            state <= IDLE;
          end else if (evt_q) begin
            io_Cmd_index  <= idx;
            io_Cmd_arg    <= arg;
            io_Cmd_crcOk  <= crc_good;
            io_Cmd_valid  <= 1'b1;
            io_FrameCount <= io_FrameCount + 8'd1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          // a held frame is never overwritten; late bytes are flagged
          if (evt_q) io_Overrun <= 1'b1;
          if (io_Cmd_valid && io_Cmd_ready) begin
            io_Cmd_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_command_framer.sv
// Directed bench for spi_command_framer: three instances share stimulus
// (SYNC=2/CRC on, SYNC=3/CRC on, SYNC=2/CRC bypassed).
module tb_spi_command_framer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] in_byte;
  logic       chg;
  logic       cs;
  logic       ready;

  logic        valid   [3];
  logic [5:0]  index   [3];
  logic [31:0] arg     [3];
  logic        crc_ok  [3];
  logic        overrun [3];
  logic [7:0]  fcount  [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spi_command_framer #(.SYNC_STAGES(2), .CHECK_CRC(1'b1)) u_a (
    .clock(clock), .reset(reset), .io_InputBuffer(in_byte),
    .io_BufferChanged(chg), .io_ChipSelect(cs), .io_Cmd_ready(ready),
    .io_Cmd_valid(valid[0]), .io_Cmd_index(index[0]),
    .io_Cmd_arg(arg[0]), .io_Cmd_crcOk(crc_ok[0]),
    .io_Overrun(overrun[0]), .io_FrameCount(fcount[0])
  );

  spi_command_framer #(.SYNC_STAGES(3), .CHECK_CRC(1'b1)) u_b (
    .clock(clock), .reset(reset), .io_InputBuffer(in_byte),
    .io_BufferChanged(chg), .io_ChipSelect(cs), .io_Cmd_ready(ready),
    .io_Cmd_valid(valid[1]), .io_Cmd_index(index[1]),
    .io_Cmd_arg(arg[1]), .io_Cmd_crcOk(crc_ok[1]),
    .io_Overrun(overrun[1]), .io_FrameCount(fcount[1])
  );

  spi_command_framer #(.SYNC_STAGES(2), .CHECK_CRC(1'b0)) u_c (
    .clock(clock), .reset(reset), .io_InputBuffer(in_byte),
    .io_BufferChanged(chg), .io_ChipSelect(cs), .io_Cmd_ready(ready),
    .io_Cmd_valid(valid[2]), .io_Cmd_index(index[2]),
    .io_Cmd_arg(arg[2]), .io_Cmd_crcOk(crc_ok[2]),
    .io_Overrun(overrun[2]), .io_FrameCount(fcount[2])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_byte = b;
    chg     = 1'b1;
    tick(6);
    chg     = 1'b0;
    tick(6);
  endtask

  task automatic send6(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    check({tag, "_drop"}, valid[0], 1'b0);
  endtask

  task automatic check_frame(input string tag, input logic [5:0] ix,
                             input logic [31:0] a, input logic ok_ab,
                             input logic ok_c, input logic [7:0] fc);
    for (int u = 0; u < 3; u++) begin
      check($sformatf("%s_u%0d_valid", tag, u), valid[u], 1'b1);
      check($sformatf("%s_u%0d_index", tag, u), index[u], ix);
      check($sformatf("%s_u%0d_arg", tag, u), arg[u], a);
      check($sformatf("%s_u%0d_crc", tag, u), crc_ok[u],
            (u == 2) ? ok_c : ok_ab);
      check($sformatf("%s_u%0d_count", tag, u), fcount[u], fc);
    end
  endtask

  initial begin
    int n_ovr;
    int lat_a;
    int lat_b;
    reset   = 1'b1;
    in_byte = 8'h00;
    chg     = 1'b0;
    cs      = 1'b0;
    ready   = 1'b0;
    tick(3);
    check("rst_valid", valid[0], 1'b0);
    check("rst_index", index[0], 6'd0);
    check("rst_arg", arg[0], 32'd0);
    check("rst_crc", crc_ok[0], 1'b0);
    check("rst_ovr", overrun[0], 1'b0);
    check("rst_count", fcount[0], 8'd0);
    reset = 1'b0;
    tick(2);

    // CMD0 preceded by idle fill
    send_byte(8'hFF);
    send6(48'h40_00_00_00_00_95);
    check_frame("cmd0", 6'd0, 32'd0, 1'b1, 1'b1, 8'd1);
    accept("cmd0");

    // reset mid-argument returns to IDLE and clears the count
    send_byte(8'h48);
    send_byte(8'h00);
    reset = 1'b1;
    tick(1);
    check("midrst_count", fcount[0], 8'd0);
    check("midrst_valid", valid[0], 1'b0);
    reset = 1'b0;
    tick(2);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h95);
    check("orphan_valid", valid[0], 1'b0);
    send6(48'h40_00_00_00_00_95);
    check_frame("post_rst", 6'd0, 32'd0, 1'b1, 1'b1, 8'd1);
    accept("post_rst");

    send6(48'h48_00_00_01_AA_87);
    check_frame("cmd8", 6'd8, 32'h1AA, 1'b1, 1'b1, 8'd2);
    accept("cmd8");
    send6(48'h48_00_00_01_AA_86);
    check_frame("endbit", 6'd8, 32'h1AA, 1'b0, 1'b0, 8'd3);
    accept("endbit");
    send6(48'h48_00_00_01_AA_89);
    check_frame("badcrc", 6'd8, 32'h1AA, 1'b0, 1'b1, 8'd4);
    accept("badcrc");

    // overrun while a frame is held
    send6(48'h40_00_00_00_00_95);
    n_ovr   = 0;
    in_byte = 8'h77;
    chg     = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 6) chg = 1'b0;
      tick(1);
      if (overrun[0]) n_ovr++;
    end
    check("ovr_pulses", n_ovr, 1);
    check_frame("ovr_hold", 6'd0, 32'd0, 1'b1, 1'b1, 8'd5);
    accept("ovr");
    send6(48'h48_00_00_01_AA_87);
    check_frame("after_ovr", 6'd8, 32'h1AA, 1'b1, 1'b1, 8'd6);
    accept("after_ovr");

    // chip-select abort; CRC7 of 51 00 00 02 00 is 0x3C
    send_byte(8'h51);
    send_byte(8'h00);
    send_byte(8'h00);
    cs = 1'b1;
    tick(4);
    cs = 1'b0;
    tick(6);
    check("abort_valid", valid[0], 1'b0);
    send6(48'h51_00_00_02_00_79);
    check_frame("cmd17", 6'd17, 32'h200, 1'b1, 1'b1, 8'd7);
    accept("cmd17");
    send6(48'h51_00_00_02_00_55);
    check_frame("bypass", 6'd17, 32'h200, 1'b0, 1'b1, 8'd8);
    accept("bypass");

    // strobe-to-valid latency
    send_byte(8'h48);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'hAA);
    in_byte = 8'h87;
    chg     = 1'b1;
    lat_a   = 0;
    lat_b   = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (valid[0] && lat_a == 0) lat_a = k;
      if (valid[1] && lat_b == 0) lat_b = k;
    end
    chg = 1'b0;
    tick(6);
    check("lat_sync2", lat_a, 4);
    check("lat_sync3", lat_b, 5);
    check_frame("lat", 6'd8, 32'h1AA, 1'b1, 1'b1, 8'd9);
    accept("lat");

    // frames 10..256 wrap the counter to zero
    for (int i = 0; i < 247; i++) begin
      send6(48'h40_00_00_00_00_95);
      accept("wrap_loop");
    end
    for (int u = 0; u < 3; u++)
      check($sformatf("wrap_u%0d_count", u), fcount[u], 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
